// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Computes a - b one bit per clock,
// LSB first, using a single full-subtractor cell and a borrow flip-flop.
// A result takes WIDTH+1 cycles from the accepted start to the done pulse.
//
// Parameters
//   WIDTH       operand / result width in bits (>= 2)
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request a subtraction; accepted in IDLE or DONE only
//   a           minuend, captured on the accepted start
//   b           subtrahend, captured on the accepted start
//   busy        high while bits are being processed (SHIFT)
//   done        one-cycle pulse, diff / borrow_out valid
//   diff        a - b modulo 2^WIDTH, held until the next accepted start
//   borrow_out  final borrow, 1 iff unsigned a < b
//   ovf         signed overflow of a - b (only with SERIAL_SUB_OVF_EN)
//
// Configuration
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output and its logic.
// ---------------------------------------------------------------------------

// Single-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic x_xor_y;

    assign x_xor_y = x ^ y;
    assign d       = x_xor_y ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    assign bout    = (~x & y) | (~x_xor_y & bin);

endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_ff;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bout;

    // The one arithmetic cell, fed by the operand LSBs and the borrow FF.
    full_sub_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow_ff),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // The result register and borrow FF are the outputs directly: they hold
    // from DONE until the next accepted start and are partial during SHIFT.
    assign diff       = res_sr;
    assign borrow_out = borrow_ff;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    // NOTE: the shift registers are reset as well, because diff is taken
    // straight from the result register and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr      <= a;
                        b_sr      <= b;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        ovf       <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    // Difference bit enters at the MSB, so after WIDTH shifts
                    // bit 0 of the result sits at bit 0 of the register.
                    res_sr    <= {cell_d, res_sr[WIDTH-1:1]};
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    borrow_ff <= cell_bout;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the cell sees the operand MSBs and
                        // produces the result MSB.
                        ovf   <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ cell_d);
`endif
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    // Back-to-back: a start here is accepted just as in IDLE.
                    if (start) begin
                        a_sr      <= a;
                        b_sr      <= b;
                        borrow_ff <= 1'b0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        ovf       <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Drives two instances (WIDTH=8 and WIDTH=4) of serial_subtractor. A
// cycle-level behavioural model predicts busy/done and the held result
// from plain integer arithmetic; a compare process checks every cycle.
// Directed cases add literal expectations that pin the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_subtractor;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic clk;
    logic rst_n;

    // Stimulus, index 0 = WIDTH 8 instance, index 1 = WIDTH 4 instance.
    logic       start_s [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];

    logic       busy8, done8, borrow8;
    logic [7:0] diff8;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;
    logic [3:0] a4, b4;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    assign a4 = a_s[1][3:0];
    assign b4 = b_s[1][3:0];

    serial_subtractor #(.WIDTH(W8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[0]),
        .a          (a_s[0]),
        .b          (b_s[0]),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(W4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[1]),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic void ref_sub(input int w, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] d, output bit bo, output bit ov);
        int ua, ub, sa, sb, r;
        ua = int'(a) % (1 << w);
        ub = int'(b) % (1 << w);
        d  = 8'((ua - ub + (1 << w)) % (1 << w));
        bo = (ua < ub);
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        r  = sa - sb;
        ov = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
    endfunction

    int         m_w    [2] = '{W8, W4};
    int         m_left [2] = '{0, 0};   // SHIFT cycles still to run
    bit         m_done [2] = '{0, 0};
    logic [7:0] m_pd   [2] = '{8'h0, 8'h0};
    bit         m_pb   [2] = '{0, 0};
    bit         m_po   [2] = '{0, 0};
    logic [7:0] m_hd   [2] = '{8'h0, 8'h0};
    bit         m_hb   [2] = '{0, 0};
    bit         m_ho   [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] = 0; m_done[i] = 0;
                m_hd[i] = 8'h0; m_hb[i] = 0; m_ho[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_done[i] = 1;
                        m_hd[i] = m_pd[i]; m_hb[i] = m_pb[i]; m_ho[i] = m_po[i];
                    end
                end else begin
                    m_done[i] = 0;
                    if (start_s[i] === 1'b1) begin
                        ref_sub(m_w[i], a_s[i], b_s[i], m_pd[i], m_pb[i], m_po[i]);
                        m_left[i] = m_w[i];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int done4_count = 0;

    always @(negedge clk) begin
        if (done4 === 1'b1) done4_count++;
        check("busy8", 32'(busy8), 32'(m_left[0] > 0));
        check("done8", 32'(done8), 32'(m_done[0]));
        check("busy4", 32'(busy4), 32'(m_left[1] > 0));
        check("done4", 32'(done4), 32'(m_done[1]));
        if (m_left[0] == 0) begin
            check("diff8", 32'(diff8), 32'(m_hd[0]));
            check("borrow8", 32'(borrow8), 32'(m_hb[0]));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf8", 32'(ovf8), 32'(m_ho[0]));
`endif
        end
        if (m_left[1] == 0) begin
            check("diff4", 32'(diff4), 32'(m_hd[1][3:0]));
            check("borrow4", 32'(borrow4), 32'(m_hb[1]));
`ifdef SERIAL_SUB_OVF_EN
            check("ovf4", 32'(ovf4), 32'(m_ho[1]));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    // Pulse start on the 8-bit instance and wait (bounded) for done;
    // verifies latency and literal results.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input bit eb, input bit eo, input string tag);
        int k;
        start_s[0] = 1'b1; a_s[0] = a; b_s[0] = b;
        k = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start_s[0] = 1'b0;
            if (done8 === 1'b1) begin k = n; break; end
        end
        check({tag, "_latency"}, 32'(k), 32'(W8 + 1));
        check({tag, "_diff"}, 32'(diff8), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow8), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
`else
        if (eo) begin end
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; a_s[i] = 8'h0; b_s[i] = 8'h0;
        end
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy8), 32'h0);
        check("rst_done", 32'(done8), 32'h0);
        check("rst_diff", 32'(diff8), 32'h0);
        check("rst_borrow", 32'(borrow8), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed literal cases.
        op8(8'h05, 8'h03, 8'h02, 0, 0, "d05_03");
        op8(8'h03, 8'h05, 8'hFE, 1, 0, "d03_05");
        op8(8'h80, 8'h01, 8'h7F, 0, 1, "d80_01");
        op8(8'h00, 8'h00, 8'h00, 0, 0, "d00_00");
        repeat (3) @(negedge clk);
        check("idle_hold_diff", 32'(diff8), 32'h00);

        // Back-to-back: start held high during SHIFT must be ignored,
        // then accepted in the DONE cycle.
        start_s[0] = 1'b1; a_s[0] = 8'h05; b_s[0] = 8'h03;
        k = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin a_s[0] = 8'hFF; b_s[0] = 8'hFF; end
            if (done8 === 1'b1) begin k = n; break; end
        end
        check("b2b_first_latency", 32'(k), 32'(W8 + 1));
        check("b2b_first_diff", 32'(diff8), 32'h02);
        check("b2b_first_borrow", 32'(borrow8), 32'h0);
        k = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start_s[0] = 1'b0;
            if (done8 === 1'b1) begin k = n; break; end
        end
        check("b2b_second_latency", 32'(k), 32'(W8 + 1));
        check("b2b_second_diff", 32'(diff8), 32'h00);
        check("b2b_second_borrow", 32'(borrow8), 32'h0);
        repeat (2) @(negedge clk);

        // Random stimulus on the 8-bit instance, start toggling freely.
        for (int n = 0; n < 400; n++) begin
            start_s[0] = 1'($urandom_range(0, 1));
            a_s[0] = 8'($urandom);
            b_s[0] = 8'($urandom);
            if (n % 50 == 0) begin a_s[0] = 8'h7F; b_s[0] = 8'h80; end
            @(negedge clk);
        end
        start_s[0] = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive back-to-back on the 4-bit instance.
        done4_count = 0;
        for (int p = 0; p < 256; p++) begin
            start_s[1] = 1'b1;
            a_s[1] = 8'(p / 16);
            b_s[1] = 8'(p % 16);
            repeat (W4 + 1) @(negedge clk);
        end
        start_s[1] = 1'b0;
        repeat (W4 + 2) @(negedge clk);
        check("exh4_done_count", 32'(done4_count), 32'd256);

        // Reset in the middle of an operation.
        start_s[0] = 1'b1; a_s[0] = 8'hFF; b_s[0] = 8'h01;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy8), 32'h0);
        check("midrst_done", 32'(done8), 32'h0);
        check("midrst_diff", 32'(diff8), 32'h0);
        check("midrst_borrow", 32'(borrow8), 32'h0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done8), 32'h0);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("post_rst_no_done", 32'(done8), 32'h0);
        end
        op8(8'h0A, 8'h04, 8'h06, 0, 0, "d0A_04");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
